// File: rtl/adder_result_collector.sv
// adder_result_collector
//   Captures the results of a pipelined adder for the cycles that carried real
//   operands and queues them in a small first-word-fall-through FIFO behind a
//   valid/ready port. A credit counter covering in-flight plus stored results
//   throttles operand issue, so a captured result always finds a free slot.
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  operand issue handshake (adder a/b driven on in_fire)
//   sum_in, cout_in      adder s / cout outputs
//   out_valid/out_ready  result handshake; out_sum/out_cout are 0 while idle
//   level                number of results stored in the FIFO
module adder_result_collector #(
    parameter int unsigned WIDTH   = 128,
    parameter int unsigned LATENCY = 4,
    parameter int unsigned DEPTH   = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           sum_in,
    input  logic                       cout_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_sum,
    output logic                       out_cout,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;
    localparam int unsigned EW = WIDTH + 1;

    logic [LATENCY-1:0] vpipe;
    logic [EW-1:0]      mem [DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [PW-1:0]      wr_ptr_nxt;
    logic [PW-1:0]      rd_ptr_nxt;
    logic [LW-1:0]      used;
    logic [LW-1:0]      used_nxt;
    logic [LW-1:0]      level_nxt;
    logic [EW-1:0]      head_nxt;
    logic               in_fire_c;
    logic               out_fire_c;
    logic               push_c;

    assign in_fire_c  = in_valid & in_ready;
    assign out_fire_c = out_valid & out_ready;
    // Tail of the valid delay line marks the cycle whose adder output is ours.
    assign push_c     = vpipe[LATENCY-1];

    // Next-state for pointers, counters and the registered FIFO head.
    always_comb begin
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        used_nxt   = used;
        level_nxt  = level;
        head_nxt   = '0;

        if (push_c) begin
            wr_ptr_nxt = wr_ptr + PW'(1);
        end
        if (out_fire_c) begin
            rd_ptr_nxt = rd_ptr + PW'(1);
        end
        used_nxt  = used + LW'(in_fire_c) - LW'(out_fire_c);
        level_nxt = level + LW'(push_c) - LW'(out_fire_c);

        // Credits guarantee a push never lands on a live entry, so a push at the
        // next read slot means the FIFO drains to just that entry: bypass it.
        if (level_nxt != '0) begin
            if (push_c && (wr_ptr == rd_ptr_nxt)) begin
                head_nxt = {cout_in, sum_in};
            end else begin
                head_nxt = mem[rd_ptr_nxt];
            end
        end
    end

    // Control state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vpipe     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            used      <= '0;
            level     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
        end else begin
            vpipe[0] <= in_fire_c;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                vpipe[i] <= vpipe[i-1];
            end
            wr_ptr              <= wr_ptr_nxt;
            rd_ptr              <= rd_ptr_nxt;
            used                <= used_nxt;
            level               <= level_nxt;
            in_ready            <= (used_nxt < LW'(DEPTH));
            out_valid           <= (level_nxt != '0);
            {out_cout, out_sum} <= head_nxt;
        end
    end

    // Result storage; contents are only observed through the occupancy-gated head.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= {cout_in, sum_in};
        end
    end

endmodule

// File: tb/tb_adder_result_collector.sv
// Bench for adder_result_collector with a behavioural 4-stage 128-bit adder in
// front of it. Expected {cout,sum} values are queued when an operand fires and
// compared when the collector hands a result out.
module tb_adder_result_collector;

    localparam int unsigned WIDTH = 128;
    localparam int unsigned LAT   = 4;
    localparam int unsigned DEPTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum_in;
    logic             cout_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic [3:0]       level;

    logic [WIDTH:0]   apipe [LAT];
    logic [WIDTH:0]   exp_q [$];

    int n_vec  = 0;
    int n_err  = 0;
    int cycle  = 0;
    int n_fire = 0;
    int used_m = 0;

    always #5 clk = ~clk;

    // Behavioural pipelined adder, cin = 0.
    always_ff @(posedge clk) begin
        apipe[0] <= {1'b0, a} + {1'b0, b};
        for (int i = 1; i < LAT; i++) begin
            apipe[i] <= apipe[i-1];
        end
    end
    assign sum_in  = apipe[LAT-1][WIDTH-1:0];
    assign cout_in = apipe[LAT-1][WIDTH];

    adder_result_collector #(.WIDTH(WIDTH), .LATENCY(LAT), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum_in    (sum_in),
        .cout_in   (cout_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .level     (level)
    );

    task automatic check(input string tag, input logic [WIDTH:0] got, input logic [WIDTH:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    // One clock: score the current cycle's handshakes, then advance to #1 past the edge.
    task automatic cyc();
        bit fire;
        bit pop;
        fire = in_valid && in_ready;
        pop  = out_valid && out_ready;
        check("in_ready", (WIDTH+1)'(in_ready), (WIDTH+1)'(used_m < int'(DEPTH)));
        if (!out_valid) begin
            check("idle_zero", {out_cout, out_sum}, '0);
        end
        if (fire) begin
            exp_q.push_back({1'b0, a} + {1'b0, b});
            n_fire++;
        end
        if (pop) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", (WIDTH+1)'(out_valid), '0);
            end else begin
                check("result", {out_cout, out_sum}, exp_q.pop_front());
            end
        end
        used_m = used_m + int'(fire) - int'(pop);
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic drain(input int max_cyc);
        int k;
        k = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && k < max_cyc) begin
            cyc();
            k++;
        end
        check("drained", (WIDTH+1)'(exp_q.size()), '0);
    endtask

    initial begin
        int t;
        int k;
        int nf0;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", (WIDTH+1)'(in_ready), (WIDTH+1)'(1));
        check("rst_out_valid", (WIDTH+1)'(out_valid), '0);
        rst_n = 1'b1;

        // 1: idle after reset
        repeat (3) cyc();
        check("idle_in_ready", (WIDTH+1)'(in_ready), (WIDTH+1)'(1));
        check("idle_out_valid", (WIDTH+1)'(out_valid), '0);
        check("idle_level", (WIDTH+1)'(level), '0);
        check("idle_sum", (WIDTH+1)'(out_sum), '0);

        // 2: single fire, minimum latency, single valid cycle
        out_ready = 1'b1;
        a = 128'h11111111;
        b = 128'h11111111;
        in_valid = 1'b1;
        t = cycle;
        cyc();
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 20) begin
            cyc();
            k++;
        end
        check("latency", (WIDTH+1)'(cycle - t), (WIDTH+1)'(5));
        check("single_sum", {out_cout, out_sum}, {1'b0, 128'h22222222});
        cyc();
        check("single_once", (WIDTH+1)'(out_valid), '0);

        // 3: four back-to-back fires, consecutive results
        for (int i = 0; i < 4; i++) begin
            a = 128'h11111111 << (8 * i);
            b = a;
            in_valid = 1'b1;
            cyc();
        end
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 20) begin
            cyc();
            k++;
        end
        for (int i = 0; i < 4; i++) begin
            check("burst_valid", (WIDTH+1)'(out_valid), (WIDTH+1)'(1));
            cyc();
        end
        check("burst_end", (WIDTH+1)'(out_valid), '0);
        drain(10);

        // 4: fill with out_ready low, then drain
        out_ready = 1'b0;
        in_valid  = 1'b1;
        nf0 = n_fire;
        k = 0;
        while (in_ready && k < 30) begin
            a = 128'(unsigned'($urandom())) << 64 | 128'(unsigned'($urandom()));
            b = 128'(unsigned'($urandom())) << 96 | 128'(k);
            cyc();
            k++;
        end
        in_valid = 1'b0;
        check("fill_fires", (WIDTH+1)'(n_fire - nf0), (WIDTH+1)'(DEPTH));
        k = 0;
        while (level != 4'(DEPTH) && k < 20) begin
            cyc();
            k++;
        end
        check("full_level", (WIDTH+1)'(level), (WIDTH+1)'(DEPTH));
        check("full_in_ready", (WIDTH+1)'(in_ready), '0);
        out_ready = 1'b1;
        cyc();
        check("credit_back", (WIDTH+1)'(in_ready), (WIDTH+1)'(1));
        drain(20);

        // 5: carry-out corner cases
        a = {WIDTH{1'b1}};
        b = 128'd1;
        in_valid = 1'b1;
        cyc();
        a = {1'b1, 127'd0};
        b = {1'b1, 127'd0};
        cyc();
        in_valid = 1'b0;
        drain(20);

        // 6: reset with 3 stored and 2 in flight
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            a = 128'(i + 1) << 100;
            b = 128'(i + 7);
            cyc();
        end
        in_valid = 1'b0;
        repeat (2) cyc();
        check("pre_rst_level", (WIDTH+1)'(level), (WIDTH+1)'(3));
        rst_n = 1'b0;
        #1;
        check("rst_now_valid", (WIDTH+1)'(out_valid), '0);
        check("rst_now_level", (WIDTH+1)'(level), '0);
        check("rst_now_ready", (WIDTH+1)'(in_ready), (WIDTH+1)'(1));
        exp_q.delete();
        used_m = 0;
        @(posedge clk);
        #1;
        cycle++;
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (10) cyc();
        check("post_rst_quiet", (WIDTH+1)'(out_valid), '0);
        a = 128'hDEAD_BEEF_0000_0001;
        b = 128'h0000_0001_FFFF_FFFF;
        in_valid = 1'b1;
        t = cycle;
        cyc();
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 20) begin
            cyc();
            k++;
        end
        check("post_rst_latency", (WIDTH+1)'(cycle - t), (WIDTH+1)'(5));
        drain(10);
        repeat (3) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
